mtm_alu_deserializer: RTL

Receives the ALU result response stream on a single serial line and rebuilds the result word, the ALU flags, the CRC and the error flags. It sits on the host/test side of the serial link, across from the serializer that produces the response. It emits one validated result per packet, or reports a framing error. Bit timing uses the same fixed clocks-per-bit prescale as the serializer.

---
 rtl/mtm_Alu_pkg.sv | 29 ++
 rtl/mtm_Alu_uart_rx.sv | 135 +++++++++++++
 rtl/mtm_alu_deserializer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mtm_Alu_pkg.sv
// Constants and types shared by the ALU response serializer and deserializer.
package mtm_Alu_pkg;

  // Frame type bit values
  localparam logic FT_DATA = 1'b0;
  localparam logic FT_CTL  = 1'b1;

  // Payload bit that marks a CTL frame as an error packet
  localparam int unsigned CTL_ERR_BIT = 7;

  // Number of DATA frames in an OK packet, sized to match the frame counter
  localparam int unsigned FCNT_W      = 3;
  localparam logic [2:0]  DATA_FRAMES = 3'd4;

  // Receiver bit-level FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BITS,
    ST_STOP_CHK,
    ST_WAIT_IDLE
  } rx_state_e;

  // Error-packet parity is good when all eight payload bits XOR to 1
  function automatic logic err_parity_ok(input logic [7:0] p);
    return ^p;
  endfunction

endpackage

// File: rtl/mtm_Alu_uart_rx.sv
// Serial frame receiver: synchronizes sin, recovers one 11-bit frame
// (start, type, 8 payload bits MSB first, stop) and reports it or a stop-bit error.
module mtm_Alu_uart_rx #(
  parameter int unsigned CLK_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sin,
  output logic       frame_valid,
  output logic       frame_type,
  output logic [7:0] payload,
  output logic       stop_err
);
  import mtm_Alu_pkg::*;

  localparam int unsigned   CW          = $clog2(CLK_PER_BIT + 1);
  localparam logic [CW-1:0] C_ONE       = CW'(1);
  localparam logic [CW-1:0] C_HALF      = CW'(CLK_PER_BIT / 2);
  localparam logic [CW-1:0] C_FULL      = CW'(CLK_PER_BIT);
  localparam logic [CW-1:0] C_IDLE_LAST = CW'(CLK_PER_BIT - 1);
  // type bit plus 8 payload bits are shifted in before the stop bit
  localparam logic [3:0]    N_SHIFT     = 4'd9;

  logic [1:0]    r_sync;
  rx_state_e     r_state;
  rx_state_e     w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [3:0]    r_bit_cnt;
  logic [3:0]    w_bit_nxt;
  logic [8:0]    r_shift;
  logic [8:0]    w_shift_nxt;
  logic          w_rxd;
  logic          w_frame_valid;
  logic          w_stop_err;

  assign w_rxd = r_sync[1];

  // Two-flop synchronizer, FSM state and bit-timing registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync    <= 2'b11;
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_sync    <= {r_sync[0], sin};
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // Next-state, bit sampling and frame/stop-error strobes.
  // The stop bit is sampled in STOP_CHK itself so the frame strobe is
  // available in the same cycle as the stop-bit sample.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_nxt     = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_frame_valid = 1'b0;
    w_stop_err    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_rxd) begin
          w_state_nxt = ST_START;
          w_cnt_nxt   = C_ONE;
        end
      end
      ST_START: begin
        if (r_cnt == C_HALF) begin
          if (w_rxd) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_BITS;
            w_cnt_nxt   = C_ONE;
            w_bit_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_BITS: begin
        if (r_cnt == C_FULL) begin
          w_cnt_nxt   = C_ONE;
          w_shift_nxt = {r_shift[7:0], w_rxd};
          w_bit_nxt   = r_bit_cnt + 1'b1;
          if (r_bit_cnt == N_SHIFT - 4'd1) begin
            w_state_nxt = ST_STOP_CHK;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_STOP_CHK: begin
        if (r_cnt == C_FULL) begin
          w_bit_nxt = r_bit_cnt + 1'b1;
          if (w_rxd) begin
            w_frame_valid = 1'b1;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_stop_err  = 1'b1;
            w_state_nxt = ST_WAIT_IDLE;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (!w_rxd) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == C_IDLE_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign frame_valid = w_frame_valid;
  assign stop_err    = w_stop_err;
  assign frame_type  = r_shift[8];
  assign payload     = r_shift[7:0];

endmodule

// File: rtl/mtm_alu_deserializer.sv
// ALU response deserializer: assembles received frames into OK or error
// results and flags malformed frames or packets.
module mtm_alu_deserializer #(
  parameter int unsigned CLK_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic [31:0] data_out,
  output logic [3:0]  alu_flags_out,
  output logic [2:0]  crc_out,
  output logic [5:0]  err_flags_out,
  output logic        parity_err,
  output logic        result_is_err,
  output logic        result_valid,
  output logic        frame_err
);
  import mtm_Alu_pkg::*;

  logic              w_frame_valid;
  logic              w_frame_type;
  logic [7:0]        w_payload;
  logic              w_stop_err;

  logic [FCNT_W-1:0] r_frame_cnt;
  logic [31:0]       r_acc;
  logic [31:0]       r_data;
  logic [3:0]        r_flags;
  logic [2:0]        r_crc;
  logic [5:0]        r_err_flags;
  logic              r_parity_err;
  logic              r_is_err;
  logic              r_valid;
  logic              r_frame_err;

  logic              w_data_ok;
  logic              w_ok_pkt;
  logic              w_err_pkt;
  logic              w_bad;

  mtm_Alu_uart_rx #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .frame_valid(w_frame_valid),
    .frame_type (w_frame_type),
    .payload    (w_payload),
    .stop_err   (w_stop_err)
  );

  // Classify each received frame against the packet position
  always_comb begin
    w_data_ok = 1'b0;
    w_ok_pkt  = 1'b0;
    w_err_pkt = 1'b0;
    w_bad     = w_stop_err;
    if (w_frame_valid) begin
      if (w_frame_type == FT_DATA) begin
        w_data_ok = (r_frame_cnt < DATA_FRAMES);
      end else if (!w_payload[CTL_ERR_BIT]) begin
        w_ok_pkt  = (r_frame_cnt == DATA_FRAMES);
      end else begin
        w_err_pkt = (r_frame_cnt == '0);
      end
      w_bad = !(w_data_ok || w_ok_pkt || w_err_pkt);
    end
  end

  // Packet tracker, accumulator and result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_frame_cnt  <= '0;
      r_acc        <= '0;
      r_data       <= '0;
      r_flags      <= '0;
      r_crc        <= '0;
      r_err_flags  <= '0;
      r_parity_err <= 1'b0;
      r_is_err     <= 1'b0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_data_ok) begin
        r_acc       <= {r_acc[23:0], w_payload};
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
      if (w_ok_pkt) begin
        r_data       <= r_acc;
        r_flags      <= w_payload[6:3];
        r_crc        <= w_payload[2:0];
        r_is_err     <= 1'b0;
        r_parity_err <= 1'b0;
        r_valid      <= 1'b1;
        r_frame_cnt  <= '0;
      end
      if (w_err_pkt) begin
        r_err_flags  <= w_payload[6:1];
        r_parity_err <= !err_parity_ok(w_payload);
        r_is_err     <= 1'b1;
        r_valid      <= 1'b1;
        r_frame_cnt  <= '0;
      end
      if (w_bad) begin
        r_frame_err <= 1'b1;
        r_frame_cnt <= '0;
      end
    end
  end

  assign data_out      = r_data;
  assign alu_flags_out = r_flags;
  assign crc_out       = r_crc;
  assign err_flags_out = r_err_flags;
  assign parity_err    = r_parity_err;
  assign result_is_err = r_is_err;
  assign result_valid  = r_valid;
  assign frame_err     = r_frame_err;

endmodule
